// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the trap sequencer: CSR op encodings, cause codes,
// FSM states and the priority-select result type.
package trap_sequencer_pkg;

  localparam logic [2:0] OP_EXCEPTION = 3'b000;
  localparam logic [2:0] OP_MRET      = 3'b001;
  localparam logic [2:0] OP_CSRRW     = 3'b010;
  localparam logic [2:0] OP_CSRRS     = 3'b011;
  localparam logic [2:0] OP_CSRRC     = 3'b100;

  // Interrupt causes carry the interrupt flag in bit 4
  localparam logic [4:0] CAUSE_EXT_INT = 5'b11011;
  localparam logic [4:0] CAUSE_SW_INT  = 5'b10011;

  localparam logic [3:0] EXC_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] EXC_INSTR_FAULT      = 4'd1;
  localparam logic [3:0] EXC_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;
  localparam logic [3:0] EXC_ECALL_U          = 4'd8;
  localparam logic [3:0] EXC_ECALL_S          = 4'd9;
  localparam logic [3:0] EXC_ECALL_H          = 4'd10;
  localparam logic [3:0] EXC_ECALL_M          = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       take;
    logic [2:0] op;
    logic [4:0] cause;
  } trap_sel_t;

endpackage

// File: rtl/trap_sequencer.sv
// Prioritises exception / interrupt / MRET at an instruction boundary, runs the
// CSR block handshake and returns the redirect PC to the core.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [4:0] EXT_INT_CAUSE = CAUSE_EXT_INT,
  parameter logic [4:0] SW_INT_CAUSE  = CAUSE_SW_INT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_exc,
  input  logic [3:0]  req_exc_code,
  input  logic        req_mret,
  input  logic [31:0] req_pc,
  input  logic        ext_int_pending,
  input  logic        sw_int_pending,
  output logic        csr_available,
  output logic [2:0]  csr_op,
  output logic [11:0] csr_addr_exception,
  output logic [31:0] csr_write_value,
  input  logic [31:0] csr_read_value,
  input  logic        csr_busy,
  input  logic        csr_fault,
  output logic        resp_valid,
  output logic        resp_trap,
  output logic [31:0] resp_pc,
  output logic        trap_error
);

  state_t      r_state, w_state_next;
  logic        r_req_ready, w_req_ready;
  logic        r_csr_available, w_csr_available;
  logic [2:0]  r_csr_op, w_csr_op;
  logic [4:0]  r_cause, w_cause;
  logic [31:0] r_csr_write_value, w_csr_write_value;
  logic        r_resp_valid, w_resp_valid;
  logic        r_resp_trap, w_resp_trap;
  logic [31:0] r_resp_pc, w_resp_pc;
  logic        r_trap_error, w_trap_error;
  logic        w_accept;
  trap_sel_t   w_sel;

  // Exception beats interrupts, external beats software, interrupts beat MRET
  function automatic trap_sel_t select_trap(input logic       exc,
                                            input logic [3:0] code,
                                            input logic       ext,
                                            input logic       sw,
                                            input logic       mret);
    trap_sel_t sel;
    sel.take  = 1'b1;
    sel.op    = OP_EXCEPTION;
    sel.cause = 5'd0;
    if (exc)       sel.cause = {1'b0, code};
    else if (ext)  sel.cause = EXT_INT_CAUSE;
    else if (sw)   sel.cause = SW_INT_CAUSE;
    else if (mret) sel.op    = OP_MRET;
    else           sel.take  = 1'b0;
    return sel;
  endfunction

  assign w_accept = req_valid & r_req_ready;
  assign w_sel    = select_trap(req_exc, req_exc_code, ext_int_pending,
                                sw_int_pending, req_mret);

  always_comb begin
    w_state_next      = r_state;
    w_csr_available   = r_csr_available;
    w_csr_op          = r_csr_op;
    w_cause           = r_cause;
    w_csr_write_value = r_csr_write_value;
    w_resp_valid      = 1'b0;
    w_resp_trap       = r_resp_trap;
    w_resp_pc         = r_resp_pc;
    w_trap_error      = r_trap_error;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_sel.take) begin
            w_csr_op          = w_sel.op;
            w_cause           = w_sel.cause;
            w_csr_write_value = req_pc;
            w_csr_available   = 1'b1;
            w_state_next      = ST_ISSUE;
          end else begin
            w_resp_trap  = 1'b0;
            w_resp_pc    = req_pc;
            w_resp_valid = 1'b1;
            w_state_next = ST_DONE;
          end
        end
      end
      ST_ISSUE: begin
        if (csr_busy) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (!csr_busy) begin
          w_resp_pc       = csr_read_value;
          w_resp_trap     = 1'b1;
          w_trap_error    = r_trap_error | csr_fault;
          w_csr_available = 1'b0;
          w_resp_valid    = 1'b1;
          w_state_next    = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_csr_available = 1'b0;
      end
    endcase
    w_req_ready = (w_state_next == ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= ST_IDLE;
      r_req_ready       <= 1'b1;
      r_csr_available   <= 1'b0;
      r_csr_op          <= 3'd0;
      r_cause           <= 5'd0;
      r_csr_write_value <= 32'd0;
      r_resp_valid      <= 1'b0;
      r_resp_trap       <= 1'b0;
      r_resp_pc         <= 32'd0;
      r_trap_error      <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_req_ready       <= w_req_ready;
      r_csr_available   <= w_csr_available;
      r_csr_op          <= w_csr_op;
      r_cause           <= w_cause;
      r_csr_write_value <= w_csr_write_value;
      r_resp_valid      <= w_resp_valid;
      r_resp_trap       <= w_resp_trap;
      r_resp_pc         <= w_resp_pc;
      r_trap_error      <= w_trap_error;
    end
  end

  assign req_ready          = r_req_ready;
  assign csr_available      = r_csr_available;
  assign csr_op             = r_csr_op;
  assign csr_addr_exception = {7'd0, r_cause};
  assign csr_write_value    = r_csr_write_value;
  assign resp_valid         = r_resp_valid;
  assign resp_trap          = r_resp_trap;
  assign resp_pc            = r_resp_pc;
  assign trap_error         = r_trap_error;

endmodule
